// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing unit for the MiniRISC decoder: owns the PC, latches IR, counts retires.
// Optional macro FETCH_SINGLE_STEP_EN adds i_Step and a STEP_WAIT state between instructions.
module fetch_sequencer #(
  parameter int unsigned PC_WIDTH  = 5,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Start,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic                 i_Step,
`endif
  output logic [PC_WIDTH-1:0]  o_Instr_Addr,
  input  logic [7:0]           i_Instr_Data,
  output logic [2:0]           o_Op,
  output logic [1:0]           o_Rdst,
  output logic [2:0]           o_Rsrc_Imm,
  output logic                 o_Instr_Valid,
  input  logic                 i_PCSelect,
  input  logic [PC_WIDTH-1:0]  i_PCAddr,
  input  logic                 i_Halt,
  output logic                 o_Running,
  output logic                 o_Halted,
  output logic [CNT_WIDTH-1:0] o_Retired
);

  localparam logic [PC_WIDTH-1:0] LP_RESET_PC = PC_WIDTH'(RESET_PC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED
`ifdef FETCH_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_t;

  state_t               r_state;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [7:0]           r_ir;
  logic                 r_valid;
  logic                 r_running;
  logic                 r_halted;
  logic [CNT_WIDTH-1:0] r_retired;
  logic [PC_WIDTH-1:0]  w_next_pc;

  assign w_next_pc = i_PCSelect ? i_PCAddr : r_pc + PC_WIDTH'(1);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state   <= S_IDLE;
      r_pc      <= LP_RESET_PC;
      r_ir      <= '0;
      r_valid   <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_Start) begin
            r_state   <= S_FETCH;
            r_running <= 1'b1;
          end
        end
        S_FETCH: begin
          r_ir    <= i_Instr_Data;
          r_valid <= 1'b1;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_valid   <= 1'b0;
          r_retired <= r_retired + CNT_WIDTH'(1);
          // Halt wins over a jump; PC stays on the HALT instruction.
          if (i_Halt) begin
            r_state   <= S_HALTED;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
          end else begin
            r_pc <= w_next_pc;
`ifdef FETCH_SINGLE_STEP_EN
            r_state <= S_STEP_WAIT;
`else
            r_state <= S_FETCH;
`endif
          end
        end
        S_HALTED: begin
          if (i_Start) begin
            r_pc      <= LP_RESET_PC;
            r_retired <= '0;
            r_state   <= S_FETCH;
            r_running <= 1'b1;
            r_halted  <= 1'b0;
          end
        end
`ifdef FETCH_SINGLE_STEP_EN
        S_STEP_WAIT: begin
          if (i_Step) r_state <= S_FETCH;
        end
`endif
        default: begin
          r_state   <= S_IDLE;
          r_valid   <= 1'b0;
          r_running <= 1'b0;
          r_halted  <= 1'b0;
        end
      endcase
    end
  end

  // Fields are forced to NOP outside EXEC so the decoder never acts on a stale IR.
  assign o_Op          = r_valid ? r_ir[7:5] : '0;
  assign o_Rdst        = r_valid ? r_ir[4:3] : '0;
  assign o_Rsrc_Imm    = r_valid ? r_ir[2:0] : '0;
  assign o_Instr_Valid = r_valid;
  assign o_Instr_Addr  = r_pc;
  assign o_Running     = r_running;
  assign o_Halted      = r_halted;
  assign o_Retired     = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: sync ROM + decoder stand-in, instruction-level reference trace.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  logic       clk;
  logic       i_Reset, i_Start, i_Step;
  logic [4:0] o_Instr_Addr;
  logic [7:0] rom_q;
  logic [2:0] o_Op;
  logic [1:0] o_Rdst;
  logic [2:0] o_Rsrc_Imm;
  logic       o_Instr_Valid;
  logic       i_PCSelect, i_Halt;
  logic [4:0] i_PCAddr;
  logic       o_Running, o_Halted;
  logic [7:0] o_Retired;

  logic [7:0] rom [32];
  logic       nz_sel, nz_halt;
  logic [4:0] nz_addr;
  int         total = 0;
  int         bad = 0;

  typedef struct packed {
    logic [4:0] addr;
    logic       v;
    logic [2:0] op;
    logic [1:0] rd;
    logic [2:0] rs;
    logic       run;
    logic       hlt;
    logic [7:0] ret;
  } exp_t;
  exp_t tq[$];

  fetch_sequencer #(.PC_WIDTH(5), .RESET_PC(0), .CNT_WIDTH(8)) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Start(i_Start),
`ifdef FETCH_SINGLE_STEP_EN
    .i_Step(i_Step),
`endif
    .o_Instr_Addr(o_Instr_Addr), .i_Instr_Data(rom_q),
    .o_Op(o_Op), .o_Rdst(o_Rdst), .o_Rsrc_Imm(o_Rsrc_Imm),
    .o_Instr_Valid(o_Instr_Valid), .i_PCSelect(i_PCSelect), .i_PCAddr(i_PCAddr),
    .i_Halt(i_Halt), .o_Running(o_Running), .o_Halted(o_Halted), .o_Retired(o_Retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: captures the address mid-cycle, data ready by the next rising edge.
  always @(negedge clk) rom_q <= rom[o_Instr_Addr];

  // Decoder stand-in: op 5 = JUMP {Rdst,Imm}, op 7 = HALT; random noise outside EXEC.
  assign i_Halt     = o_Instr_Valid ? (o_Op == 3'd7) : nz_halt;
  assign i_PCSelect = o_Instr_Valid ? (o_Op == 3'd5) : nz_sel;
  assign i_PCAddr   = o_Instr_Valid ? {o_Rdst, o_Rsrc_Imm} : nz_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    nz_sel  = 1'($urandom);
    nz_halt = 1'($urandom);
    nz_addr = 5'($urandom);
  endtask

  task automatic check_entry(input exp_t e);
    chk("addr",    32'(o_Instr_Addr),  32'(e.addr));
    chk("valid",   32'(o_Instr_Valid), 32'(e.v));
    chk("op",      32'(o_Op),          32'(e.op));
    chk("rdst",    32'(o_Rdst),        32'(e.rd));
    chk("rsrc",    32'(o_Rsrc_Imm),    32'(e.rs));
    chk("running", 32'(o_Running),     32'(e.run));
    chk("halted",  32'(o_Halted),      32'(e.hlt));
    chk("retired", 32'(o_Retired),     32'(e.ret));
  endtask

  // Instruction-level model: each instruction is a fetch cycle then an exec cycle.
  function automatic void build(input int n);
    logic [4:0] pc;
    logic [7:0] ret;
    logic [7:0] ins;
    logic       halted;
    pc = '0; ret = '0; halted = 1'b0;
    tq.delete();
    for (int i = 0; i < n; i++) begin
      ins = rom[pc];
      tq.push_back('{pc, 1'b0, 3'd0, 2'd0, 3'd0, 1'b1, 1'b0, ret});
      tq.push_back('{pc, 1'b1, ins[7:5], ins[4:3], ins[2:0], 1'b1, 1'b0, ret});
      ret = ret + 8'd1;
      if (ins[7:5] == 3'd7) begin
        halted = 1'b1;
        break;
      end
      pc = (ins[7:5] == 3'd5) ? ins[4:0] : pc + 5'd1;
`ifdef FETCH_SINGLE_STEP_EN
      tq.push_back('{pc, 1'b0, 3'd0, 2'd0, 3'd0, 1'b1, 1'b0, ret});
`endif
    end
    if (halted)
      for (int k = 0; k < 3; k++) tq.push_back('{pc, 1'b0, 3'd0, 2'd0, 3'd0, 1'b0, 1'b1, ret});
  endfunction

  task automatic do_reset();
    i_Reset = 1'b1;
    adv();
    i_Reset = 1'b0;
  endtask

  task automatic run_program(input int n);
    build(n);
    do_reset();
    i_Start = 1'b1;
    adv();
    i_Start = 1'b0;
    foreach (tq[k]) begin
      check_entry(tq[k]);
      adv();
    end
  endtask

  task automatic rom_fill(input logic [7:0] val);
    for (int a = 0; a < 32; a++) rom[a] = val;
  endtask

  initial begin
    i_Reset = 1'b0; i_Start = 1'b0; i_Step = 1'b1;
    nz_sel = 1'b0; nz_halt = 1'b0; nz_addr = '0;
    rom_fill(8'h00);

    // Reset state, with start asserted to show reset dominance
    i_Start = 1'b1;
    do_reset();
    i_Start = 1'b0;
    check_entry('{5'd0, 1'b0, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0, 8'd0});

    // All-NOP stream: 0,0,1,1,2,2 and retired=3 after six cycles
    run_program(3);
    chk("nop_retired3", 32'(o_Retired), 32'd3);

    // JUMP 20 at address 3
    rom_fill(8'h00);
    rom[3] = 8'hB4;
    run_program(6);

    // PC wrap 31->0 and retired counter wrap 255->0
    rom_fill(8'h00);
    run_program(260);

    // HALT at address 5, then restart
    rom_fill(8'h00);
    rom[5] = 8'hE0;
    run_program(20);
    chk("halt_addr", 32'(o_Instr_Addr), 32'd5);
    chk("halt_ret",  32'(o_Retired),    32'd6);
    i_Start = 1'b1;
    adv();
    i_Start = 1'b0;
    check_entry('{5'd0, 1'b0, 3'd0, 2'd0, 3'd0, 1'b1, 1'b0, 8'd0});
    adv();
    chk("restart_valid", 32'(o_Instr_Valid), 32'd1);

    // Reset during EXEC of the instruction at address 2
    rom_fill(8'h00);
    do_reset();
    i_Start = 1'b1;
    adv();
    i_Start = 1'b0;
    for (int c = 0; c < 5; c++) adv();
    chk("pre_rst_valid", 32'(o_Instr_Valid), 32'd1);
    chk("pre_rst_addr",  32'(o_Instr_Addr),  32'd2);
    chk("pre_rst_ret",   32'(o_Retired),     32'd2);
    i_Reset = 1'b1;
    adv();
    i_Reset = 1'b0;
    check_entry('{5'd0, 1'b0, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0, 8'd0});
    adv();
    check_entry('{5'd0, 1'b0, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0, 8'd0});

    // Random programs against the model
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 32; a++) rom[a] = 8'($urandom);
      run_program(40);
    end

`ifdef FETCH_SINGLE_STEP_EN
    begin
      int vcount;
      rom_fill(8'h00);
      do_reset();
      i_Step = 1'b0;
      i_Start = 1'b1;
      adv();
      i_Start = 1'b0;
      adv();
      chk("step_first_exec", 32'(o_Instr_Valid), 32'd1);
      for (int c = 0; c < 3; c++) begin
        adv();
        check_entry('{5'd1, 1'b0, 3'd0, 2'd0, 3'd0, 1'b1, 1'b0, 8'd1});
      end
      i_Step = 1'b1;
      adv();
      i_Step = 1'b0;
      vcount = 0;
      for (int c = 0; c < 8; c++) begin
        if (o_Instr_Valid) vcount++;
        adv();
      end
      chk("step_one_pulse", 32'(vcount), 32'd1);
      chk("step_park_addr", 32'(o_Instr_Addr), 32'd2);
      chk("step_park_ret",  32'(o_Retired), 32'd2);
      i_Step = 1'b1;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
